// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit vector-encryption CPU pipeline.
package cpu_pkg;

  localparam int DATA_W    = 16;
  localparam int REG_IDX_W = 4;

  // Writeback mux select. The MEM stage passes it through unchanged.
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC2 = 2'b10
  } resultSrcT;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write and asynchronous read.
// Contents start at zero at power-up and are never cleared by reset.
module data_mem
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] readData
);

  localparam int DEPTH = 2 ** ADDR_W;

  // The power-up value comes from the declaration, so reads are never X.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  // Full-word store on the rising edge.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[addr] <= writeData;
    end
  end

  // Combinational read. A same-edge store is visible only from the next cycle,
  // which is what gives the pipeline register read-before-write behaviour.
  assign readData = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// MEM stage: performs the data-memory access addressed by the ALU result
// and registers everything the writeback stage needs into MEM/WB.
module memory_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 regWriteM,
  input  logic                 memWriteM,
  input  logic [DATA_W-1:0]    aluResM,
  input  logic [DATA_W-1:0]    writeDataM,
  input  logic [DATA_W-1:0]    PCPlus2M,
  input  logic [REG_IDX_W-1:0] RdM,
  input  logic [1:0]           resultSrcM,
  output logic [DATA_W-1:0]    PCPlus2W,
  output logic [DATA_W-1:0]    aluResW,
  output logic [DATA_W-1:0]    readDataW,
  output logic [DATA_W-1:0]    writeDataW,
  output logic [REG_IDX_W-1:0] RdW,
  output logic                 regWriteW,
  output logic [1:0]           resultSrcW
);

  logic [ADDR_W-1:0] dmIndex;
  logic [DATA_W-1:0] dmReadData;
  logic              dmWriteEn;

  // Upper address bits are dropped, so addresses alias modulo the DM depth.
  assign dmIndex   = aluResM[ADDR_W-1:0];
  // Stores are blocked while reset is held; contents survive the reset.
  assign dmWriteEn = memWriteM & ~rst;

  data_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) uDataMem (
    .clk      (clk),
    .writeEn  (dmWriteEn),
    .addr     (dmIndex),
    .writeData(writeDataM),
    .readData (dmReadData)
  );

  // MEM/WB pipeline register: loads every cycle, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PCPlus2W   <= '0;
      aluResW    <= '0;
      readDataW  <= '0;
      writeDataW <= '0;
      RdW        <= '0;
      regWriteW  <= 1'b0;
      resultSrcW <= '0;
    end else begin
      PCPlus2W   <= PCPlus2M;
      aluResW    <= aluResM;
      readDataW  <= dmReadData;
      writeDataW <= writeDataM;
      RdW        <= RdM;
      regWriteW  <= regWriteM;
      resultSrcW <= resultSrcM;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage with directed and randomized traffic
// against an array-based model of the data memory.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        regWriteM, memWriteM;
  logic [15:0] aluResM, writeDataM, PCPlus2M;
  logic [3:0]  RdM;
  logic [1:0]  resultSrcM;
  logic [15:0] PCPlus2W, aluResW, readDataW, writeDataW;
  logic [3:0]  RdW;
  logic        regWriteW;
  logic [1:0]  resultSrcW;

  int checks   = 0;
  int failures = 0;

  // Reference memory: 256 words, zero at power-up.
  logic [15:0] refMem [256];

  memory_stage #(.DATA_W(16), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .aluResM(aluResM),
    .writeDataM(writeDataM), .PCPlus2M(PCPlus2M), .RdM(RdM), .resultSrcM(resultSrcM),
    .PCPlus2W(PCPlus2W), .aluResW(aluResW), .readDataW(readDataW),
    .writeDataW(writeDataW), .RdW(RdW), .regWriteW(regWriteW), .resultSrcW(resultSrcW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic chkAllZero(input string tag);
    chk({tag, ".PCPlus2W"},   PCPlus2W,   16'h0);
    chk({tag, ".aluResW"},    aluResW,    16'h0);
    chk({tag, ".readDataW"},  readDataW,  16'h0);
    chk({tag, ".writeDataW"}, writeDataW, 16'h0);
    chk({tag, ".RdW"},        {12'h0, RdW},        16'h0);
    chk({tag, ".regWriteW"},  {15'h0, regWriteW},  16'h0);
    chk({tag, ".resultSrcW"}, {14'h0, resultSrcW}, 16'h0);
  endtask

  task automatic drive(input logic rw, input logic mw, input logic [15:0] alu,
                       input logic [15:0] wd, input logic [15:0] pc,
                       input logic [3:0] rd, input logic [1:0] rs);
    regWriteM = rw; memWriteM = mw; aluResM = alu;
    writeDataM = wd; PCPlus2M = pc; RdM = rd; resultSrcM = rs;
  endtask

  // One normal cycle: the W stage must show this cycle's M inputs, with the
  // memory word as it was before any store on the same edge.
  task automatic step(input string tag, input logic rw, input logic mw,
                      input logic [15:0] alu, input logic [15:0] wd,
                      input logic [15:0] pc, input logic [3:0] rd,
                      input logic [1:0] rs, input bit checkAll);
    logic [15:0] expRead;
    drive(rw, mw, alu, wd, pc, rd, rs);
    @(posedge clk);
    expRead = refMem[alu[7:0]];
    if (mw) refMem[alu[7:0]] = wd;
    #1;
    chk({tag, ".readDataW"}, readDataW, expRead);
    if (checkAll) begin
      chk({tag, ".PCPlus2W"},   PCPlus2W,   pc);
      chk({tag, ".aluResW"},    aluResW,    alu);
      chk({tag, ".writeDataW"}, writeDataW, wd);
      chk({tag, ".RdW"},        {12'h0, RdW},        {12'h0, rd});
      chk({tag, ".regWriteW"},  {15'h0, regWriteW},  {15'h0, rw});
      chk({tag, ".resultSrcW"}, {14'h0, resultSrcW}, {14'h0, rs});
    end
  endtask

  initial begin
    foreach (refMem[i]) refMem[i] = 16'h0;

    // Reset held over two edges with a live store request: outputs stay 0.
    rst = 1'b1;
    drive(1'b1, 1'b1, 16'h0010, 16'hAAAA, 16'h1234, 4'hF, 2'b10);
    repeat (2) begin
      @(posedge clk); #1;
      chkAllZero("reset");
    end
    @(negedge clk);
    rst = 1'b0;
    #1;

    // The blocked store must not have reached the memory.
    step("rstNoWrite", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0002, 4'h1, 2'b01, 1'b0);
    chk("rstNoWrite.mem", readDataW, 16'h0000);

    // Store then load.
    step("st0", 1'b0, 1'b1, 16'h0000, 16'h5678, 16'h0002, 4'h0, 2'b00, 1'b1);
    step("st1", 1'b0, 1'b1, 16'h0001, 16'h5008, 16'h0004, 4'h0, 2'b00, 1'b1);
    step("ld0", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0006, 4'h3, 2'b01, 1'b1);
    chk("ld0.value", readDataW, 16'h5678);
    step("ld1", 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0008, 4'h4, 2'b01, 1'b1);
    chk("ld1.value", readDataW, 16'h5008);

    // Pass-through of the control/link fields.
    step("pass", 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0004, 4'hC, 2'b01, 1'b1);

    // Read-before-write on the same index.
    step("rbwInit", 1'b0, 1'b1, 16'h0002, 16'h1111, 16'h000A, 4'h0, 2'b00, 1'b1);
    step("rbwSame", 1'b0, 1'b1, 16'h0002, 16'h2222, 16'h000C, 4'h0, 2'b00, 1'b1);
    chk("rbwSame.old", readDataW, 16'h1111);
    step("rbwNext", 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h000E, 4'h5, 2'b01, 1'b1);
    chk("rbwNext.new", readDataW, 16'h2222);

    // Upper address bits alias onto the same word.
    step("aliasSt", 1'b0, 1'b1, 16'h0103, 16'hBEEF, 16'h0010, 4'h0, 2'b00, 1'b1);
    step("aliasLd", 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0012, 4'h6, 2'b01, 1'b1);
    chk("aliasLd.value", readDataW, 16'hBEEF);

    // Async reset between edges with a store request to address 0.
    drive(1'b1, 1'b1, 16'h0000, 16'hDEAD, 16'h0014, 4'h7, 2'b10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chkAllZero("asyncRst");
    @(posedge clk); #1;
    chkAllZero("asyncRstHeld");
    @(negedge clk);
    rst = 1'b0;
    #1;
    step("postRst", 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0016, 4'h8, 2'b01, 1'b1);
    chk("postRst.preserved", readDataW, 16'h5678);

    // Randomized traffic; a narrow address window keeps stores and loads colliding.
    for (int n = 0; n < 400; n++) begin
      logic [15:0] a;
      a = {$urandom_range(0, 255), 8'h00} | 16'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) a = 16'($urandom);
      step("rand", 1'($urandom), 1'($urandom_range(0, 2) == 0), a,
           16'($urandom), 16'($urandom), 4'($urandom), 2'($urandom_range(0, 2)), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
